// File: rtl/gardner_iq_agc_if.sv
// -----------------------------------------------------------------------------
// gardner_iq_agc_if
// I/Q sample bus between the matched filter, the gain pre-processor and the
// Gardner timing-error detector.
//   I_in_tdata / I_in_tvalid   : signed I sample into the pre-processor
//   Q_in_tdata / Q_in_tvalid   : signed Q sample into the pre-processor
//   I_out_tdata / I_out_tvalid : scaled, saturated I out of the pre-processor
//   Q_out_tdata / Q_out_tvalid : scaled, saturated Q out of the pre-processor
// master : the side that sources input samples and consumes scaled samples
// slave  : the pre-processor itself
// -----------------------------------------------------------------------------
interface gardner_iq_agc_if #(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 16
);
    logic signed [WIDTH-1:0]     I_in_tdata;
    logic                        I_in_tvalid;
    logic signed [WIDTH-1:0]     Q_in_tdata;
    logic                        Q_in_tvalid;
    logic signed [OUT_WIDTH-1:0] I_out_tdata;
    logic                        I_out_tvalid;
    logic signed [OUT_WIDTH-1:0] Q_out_tdata;
    logic                        Q_out_tvalid;

    modport master (
        output I_in_tdata, I_in_tvalid, Q_in_tdata, Q_in_tvalid,
        input  I_out_tdata, I_out_tvalid, Q_out_tdata, Q_out_tvalid
    );

    modport slave (
        input  I_in_tdata, I_in_tvalid, Q_in_tdata, Q_in_tvalid,
        output I_out_tdata, I_out_tvalid, Q_out_tdata, Q_out_tvalid
    );
endinterface

// File: rtl/gardner_iq_agc.sv
// -----------------------------------------------------------------------------
// gardner_iq_agc
// I/Q pre-processor ahead of the Gardner timing-error detector. Each accepted
// I/Q pair is arithmetically right-shifted by shift_cur and saturated to
// OUT_WIDTH. The shift is either forced from fixed_shift (auto_en = 0) or
// derived from the peak magnitude over windows of 2^WIN_LOG2 accepted samples.
// Ports:
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   bus         : I/Q input and output streams (slave side)
//   auto_en     : 1 = automatic gain control, 0 = manual shift
//   fixed_shift : manual shift amount
//   shift_cur   : shift currently applied to accepted samples
//   sat         : output sample of this cycle was clipped on I or Q
//   locked      : automatic tracking has settled on the target shift
// -----------------------------------------------------------------------------
module gardner_iq_agc #(
    parameter int WIDTH      = 16,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT_W    = 3,
    parameter int WIN_LOG2   = 6,
    parameter int TARGET_MSB = 12,
    parameter int INIT_SHIFT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    gardner_iq_agc_if.slave    bus,
    input  logic               auto_en,
    input  logic [SHIFT_W-1:0] fixed_shift,
    output logic [SHIFT_W-1:0] shift_cur,
    output logic               sat,
    output logic               locked
);

    localparam int MAG_W     = WIDTH - 1;
    localparam int P_W       = $clog2(WIDTH);
    localparam int MAX_SHIFT = (1 << SHIFT_W) - 1;

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_ACQ    = 2'd1,
        ST_TRACK  = 2'd2
    } state_t;

    // |x| with the most negative code clamped so it fits in WIDTH-1 bits
    function automatic logic [MAG_W-1:0] abs_sat(input logic signed [WIDTH-1:0] x);
        logic [MAG_W-1:0] r;
        if (x[WIDTH-1] == 1'b0) begin
            r = x[MAG_W-1:0];
        end else if (x[MAG_W-1:0] == {MAG_W{1'b0}}) begin
            r = {MAG_W{1'b1}};
        end else begin
            r = MAG_W'($unsigned(-x));
        end
        return r;
    endfunction

    // Index of the highest set bit; 0 when the input is 0
    function automatic logic [P_W-1:0] msb_index(input logic [MAG_W-1:0] m);
        logic [P_W-1:0] idx;
        idx = {P_W{1'b0}};
        for (int i = 0; i < MAG_W; i++) begin
            if (m[i]) begin
                idx = P_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Shift that would bring the peak's top bit to TARGET_MSB, clamped
    function automatic logic [SHIFT_W-1:0] target_of(input logic [P_W-1:0] p);
        int diff;
        logic [SHIFT_W-1:0] r;
        diff = int'(p) - TARGET_MSB;
        if (diff < 0) begin
            r = {SHIFT_W{1'b0}};
        end else if (diff > MAX_SHIFT) begin
            r = SHIFT_W'(MAX_SHIFT);
        end else begin
            r = SHIFT_W'(diff);
        end
        return r;
    endfunction

    // Arithmetic shift then saturate; result is {clipped, value}.
    // The shifted value fits when every bit from the sign down to the output
    // sign position agrees.
    function automatic logic [OUT_WIDTH:0] scale_sat(
        input logic signed [WIDTH-1:0] x,
        input logic [SHIFT_W-1:0]      sh
    );
        logic signed [WIDTH-1:0] y;
        logic [OUT_WIDTH:0]      r;
        y = x >>> sh;
        if ((&y[WIDTH-1:OUT_WIDTH-1]) || (~|y[WIDTH-1:OUT_WIDTH-1])) begin
            r = {1'b0, y[OUT_WIDTH-1:0]};
        end else if (y[WIDTH-1]) begin
            r = {1'b1, 1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
            r = {1'b1, 1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
        return r;
    endfunction

    state_t                      state_q, state_d;
    logic [SHIFT_W-1:0]          shift_q, shift_d;
    logic [WIN_LOG2-1:0]         cnt_q, cnt_d;
    logic [MAG_W-1:0]            peak_q, peak_d;
    logic                        locked_q, locked_d;
    logic signed [OUT_WIDTH-1:0] i_out_q, i_out_d;
    logic signed [OUT_WIDTH-1:0] q_out_q, q_out_d;
    logic                        vld_q, vld_d;
    logic                        sat_q, sat_d;

    logic                        accept_s;
    logic [OUT_WIDTH:0]          sc_i_s, sc_q_s;
    logic [MAG_W-1:0]            mag_i_s, mag_q_s, mag_s, peak_win_s;
    logic [SHIFT_W-1:0]          target_s;
    logic                        last_s;

    // Acceptance, magnitude and the window peak including the current sample
    always_comb begin
        accept_s   = bus.I_in_tvalid & bus.Q_in_tvalid;
        mag_i_s    = abs_sat(bus.I_in_tdata);
        mag_q_s    = abs_sat(bus.Q_in_tdata);
        if (mag_i_s > mag_q_s) begin
            mag_s = mag_i_s;
        end else begin
            mag_s = mag_q_s;
        end
        if (mag_s > peak_q) begin
            peak_win_s = mag_s;
        end else begin
            peak_win_s = peak_q;
        end
        target_s = target_of(msb_index(peak_win_s));
        last_s   = &cnt_q;
    end

    // Datapath: scale and saturate with the shift in force at acceptance
    always_comb begin
        sc_i_s = scale_sat(bus.I_in_tdata, shift_q);
        sc_q_s = scale_sat(bus.Q_in_tdata, shift_q);
        if (accept_s) begin
            vld_d   = 1'b1;
            i_out_d = sc_i_s[OUT_WIDTH-1:0];
            q_out_d = sc_q_s[OUT_WIDTH-1:0];
            sat_d   = sc_i_s[OUT_WIDTH] | sc_q_s[OUT_WIDTH];
        end else begin
            vld_d   = 1'b0;
            i_out_d = {OUT_WIDTH{1'b0}};
            q_out_d = {OUT_WIDTH{1'b0}};
            sat_d   = 1'b0;
        end
    end

    // Gain-control FSM: next state, shift, window counter, peak and lock
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        peak_d   = peak_q;
        locked_d = locked_q;
        if (!auto_en) begin
            // Manual from any state: a partial window is thrown away
            state_d  = ST_MANUAL;
            shift_d  = fixed_shift;
            cnt_d    = {WIN_LOG2{1'b0}};
            peak_d   = {MAG_W{1'b0}};
            locked_d = 1'b0;
        end else begin
            case (state_q)
                ST_MANUAL: begin
                    // Acquisition starts from whatever shift is in force
                    state_d  = ST_ACQ;
                    cnt_d    = {WIN_LOG2{1'b0}};
                    peak_d   = {MAG_W{1'b0}};
                    locked_d = 1'b0;
                end
                ST_ACQ: begin
                    if (accept_s && last_s) begin
                        shift_d = target_s;
                        state_d = ST_TRACK;
                        cnt_d   = {WIN_LOG2{1'b0}};
                        peak_d  = {MAG_W{1'b0}};
                    end else if (accept_s) begin
                        cnt_d  = cnt_q + WIN_LOG2'(1);
                        peak_d = peak_win_s;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_TRACK: begin
                    if (accept_s && last_s) begin
                        // Slew by one step per window to avoid gain jumps
                        if (target_s > shift_q) begin
                            shift_d = shift_q + SHIFT_W'(1);
                        end else if (target_s < shift_q) begin
                            shift_d = shift_q - SHIFT_W'(1);
                        end else begin
                            shift_d = shift_q;
                        end
                        locked_d = (target_s == shift_q);
                        cnt_d    = {WIN_LOG2{1'b0}};
                        peak_d   = {MAG_W{1'b0}};
                    end else if (accept_s) begin
                        cnt_d  = cnt_q + WIN_LOG2'(1);
                        peak_d = peak_win_s;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                default: begin
                    state_d  = ST_ACQ;
                    cnt_d    = {WIN_LOG2{1'b0}};
                    peak_d   = {MAG_W{1'b0}};
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    // State and control registers; reset lands in ACQ so that with auto_en
    // low the first edge after release moves to MANUAL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_ACQ;
            shift_q  <= SHIFT_W'(INIT_SHIFT);
            cnt_q    <= {WIN_LOG2{1'b0}};
            peak_q   <= {MAG_W{1'b0}};
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            peak_q   <= peak_d;
            locked_q <= locked_d;
        end
    end

    // Output registers: one cycle from acceptance to output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_out_q <= {OUT_WIDTH{1'b0}};
            q_out_q <= {OUT_WIDTH{1'b0}};
            vld_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            i_out_q <= i_out_d;
            q_out_q <= q_out_d;
            vld_q   <= vld_d;
            sat_q   <= sat_d;
        end
    end

    assign bus.I_out_tdata  = i_out_q;
    assign bus.Q_out_tdata  = q_out_q;
    assign bus.I_out_tvalid = vld_q;
    assign bus.Q_out_tvalid = vld_q;
    assign shift_cur        = shift_q;
    assign sat              = sat_q;
    assign locked           = locked_q;

endmodule

// File: tb/tb_gardner_iq_agc.sv
// -----------------------------------------------------------------------------
// tb_gardner_iq_agc
// Directed bench for gardner_iq_agc (WIDTH=16, OUT_WIDTH=12, TARGET_MSB=9,
// WIN_LOG2=6, INIT_SHIFT=0). Expected output words are computed from an
// independent shift/saturate model and queued at drive time, then popped and
// compared when the registered output appears.
// -----------------------------------------------------------------------------
module tb_gardner_iq_agc;

    localparam int WIDTH      = 16;
    localparam int OUT_WIDTH  = 12;
    localparam int SHIFT_W    = 3;
    localparam int WIN_LOG2   = 6;
    localparam int TARGET_MSB = 9;
    localparam int INIT_SHIFT = 0;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               auto_en;
    logic [SHIFT_W-1:0] fixed_shift;
    logic [SHIFT_W-1:0] shift_cur;
    logic               sat;
    logic               locked;

    int total = 0;
    int bad   = 0;

    // {I valid, Q valid, I data, Q data, sat}
    typedef logic [2+2*OUT_WIDTH:0] out_word_t;
    out_word_t sb[$];

    gardner_iq_agc_if #(.WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();

    gardner_iq_agc #(
        .WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH), .SHIFT_W(SHIFT_W),
        .WIN_LOG2(WIN_LOG2), .TARGET_MSB(TARGET_MSB), .INIT_SHIFT(INIT_SHIFT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .auto_en(auto_en),
        .fixed_shift(fixed_shift), .shift_cur(shift_cur), .sat(sat), .locked(locked)
    );

    always #5 clk = ~clk;

    // Reference: arithmetic shift then clamp to the 12-bit signed range
    function automatic logic [OUT_WIDTH:0] model(input int x, input int sh);
        int y;
        y = x >>> sh;
        if (y > 2047) begin
            return {1'b1, 12'h7FF};
        end else if (y < -2048) begin
            return {1'b1, 12'h800};
        end else begin
            return {1'b0, 12'(y)};
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of input, queue the expectation, compare one cycle later
    task automatic send(input logic vi, input logic vq, input int di, input int dq, input int sh);
        out_word_t e;
        out_word_t got;
        logic [OUT_WIDTH:0] ri, rq;
        bus.I_in_tdata  = 16'(di);
        bus.Q_in_tdata  = 16'(dq);
        bus.I_in_tvalid = vi;
        bus.Q_in_tvalid = vq;
        if (vi && vq) begin
            ri = model(di, sh);
            rq = model(dq, sh);
            e  = {1'b1, 1'b1, ri[OUT_WIDTH-1:0], rq[OUT_WIDTH-1:0], ri[OUT_WIDTH] | rq[OUT_WIDTH]};
        end else begin
            e = '0;
        end
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        got = {bus.I_out_tvalid, bus.Q_out_tvalid, bus.I_out_tdata, bus.Q_out_tdata, sat};
        e   = sb.pop_front();
        total++;
        assert (got === e) else begin
            bad++;
            $error("FAIL sample di=%0d dq=%0d sh=%0d observed=%0h expected=%0h", di, dq, sh, got, e);
        end
    endtask

    // n samples of +/-amp with shift sh; optional valid gaps mid-window
    task automatic window(input string tag, input int amp, input int sh, input bit gaps,
                          input int n, input int exp_shift, input logic exp_lock);
        for (int k = 0; k < n; k++) begin
            if (gaps && k == 20) begin
                send(1'b0, 1'b0, 0, 0, sh);
                send(1'b1, 1'b0, 30000, 0, sh);
                send(1'b0, 1'b1, 0, 30000, sh);
                send(1'b0, 1'b0, 0, 0, sh);
            end
            if (k == n - 1) begin
                chk($sformatf("%s_shift_before_end", tag), 64'(shift_cur), 64'(sh));
            end
            send(1'b1, 1'b1, amp, ((k % 2) == 1) ? -amp : amp, sh);
        end
        chk($sformatf("%s_shift", tag), 64'(shift_cur), 64'(exp_shift));
        chk($sformatf("%s_locked", tag), 64'(locked), 64'(exp_lock));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        auto_en         = 1'b0;
        fixed_shift     = 3'd5;
        bus.I_in_tdata  = 16'sd0;
        bus.Q_in_tdata  = 16'sd0;
        bus.I_in_tvalid = 1'b0;
        bus.Q_in_tvalid = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 64'({bus.I_out_tvalid, bus.Q_out_tvalid, bus.I_out_tdata,
                                   bus.Q_out_tdata, sat, locked}), 64'd0);
        chk("reset_shift", 64'(shift_cur), 64'd0);
        rst_n = 1'b1;

        // Manual scaling
        fixed_shift = 3'd2;
        send(1'b0, 1'b0, 0, 0, 2);
        chk("manual_shift2", 64'(shift_cur), 64'd2);
        send(1'b1, 1'b1, -100, 37, 2);
        send(1'b1, 1'b0, -100, 37, 2);
        send(1'b0, 1'b1, -100, 37, 2);

        // Saturation
        fixed_shift = 3'd0;
        send(1'b0, 1'b0, 0, 0, 0);
        send(1'b1, 1'b1, 32767, -32768, 0);

        // Acquisition from shift 4
        fixed_shift = 3'd4;
        send(1'b0, 1'b0, 0, 0, 4);
        chk("manual_shift4", 64'(shift_cur), 64'd4);
        auto_en = 1'b1;
        send(1'b0, 1'b0, 0, 0, 4);
        chk("acq_start_shift", 64'(shift_cur), 64'd4);
        window("acq", 8000, 4, 1'b0, 64, 3, 1'b0);
        send(1'b1, 1'b1, 8000, 0, 3);

        // Tracking: the first window still contains the 8000 sample
        window("trk0", 200, 3, 1'b0, 63, 3, 1'b1);
        window("trk1", 200, 3, 1'b1, 64, 2, 1'b0);
        window("trk2", 200, 2, 1'b0, 64, 1, 1'b0);
        window("trk3", 200, 1, 1'b0, 64, 0, 1'b0);
        window("trk4", 200, 0, 1'b1, 64, 0, 1'b1);

        // Mode switch mid-window, then re-acquire with a full window
        for (int k = 0; k < 20; k++) begin
            send(1'b1, 1'b1, 200, -200, 0);
        end
        auto_en     = 1'b0;
        fixed_shift = 3'd4;
        send(1'b1, 1'b1, 200, -200, 0);
        chk("switch_shift", 64'(shift_cur), 64'd4);
        chk("switch_locked", 64'(locked), 64'd0);
        auto_en = 1'b1;
        send(1'b0, 1'b0, 0, 0, 4);
        window("reacq", 200, 4, 1'b0, 64, 0, 1'b0);
        window("up", 8000, 0, 1'b0, 64, 1, 1'b0);

        // Asynchronous reset mid-window in TRACK
        for (int k = 0; k < 10; k++) begin
            send(1'b1, 1'b1, 1000, -1000, 1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", 64'({bus.I_out_tvalid, bus.Q_out_tvalid, bus.I_out_tdata,
                                       bus.Q_out_tdata, sat, locked}), 64'd0);
        chk("async_rst_shift", 64'(shift_cur), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Abs corner: most negative Q is the window peak
        for (int k = 0; k < 64; k++) begin
            if (k == 63) begin
                chk("abs_shift_before_end", 64'(shift_cur), 64'd0);
            end
            if (k == 30) begin
                send(1'b1, 1'b1, 0, -32768, 0);
            end else begin
                send(1'b1, 1'b1, 100, 50, 0);
            end
        end
        chk("abs_shift", 64'(shift_cur), 64'd5);
        chk("abs_locked", 64'(locked), 64'd0);
        send(1'b1, 1'b1, 1000, -1000, 5);
        send(1'b0, 1'b0, 0, 0, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gardner_iq_agc.md
# gardner_iq_agc

Parametrised I/Q pre-processor for the Gardner timing loop with automatic block-based gain control. It scales the I/Q stream by an arithmetic right shift and saturates the result to the output width. The shift is either forced by a manual input or tracked automatically from the peak magnitude over fixed sample windows. It sits between the matched filter and the Gardner timing-error detector.

## Interface
- WIDTH, 16: input sample width (signed)
- OUT_WIDTH, 16: output sample width (signed); must be ≤ WIDTH
- SHIFT_W, 3: shift field width; MAX_SHIFT = 2^SHIFT_W − 1
- WIN_LOG2, 6: window length = 2^WIN_LOG2 accepted samples
- TARGET_MSB, 12: desired bit index of the peak magnitude after shifting; must be ≤ OUT_WIDTH−2
- INIT_SHIFT, 2: shift loaded at reset
- clk  in  1  clock; everything is on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- I_in_tdata  in  WIDTH  signed I sample
- I_in_tvalid  in  1  I valid
- Q_in_tdata  in  WIDTH  signed Q sample
- Q_in_tvalid  in  1  Q valid
- auto_en  in  1  1 = automatic gain control, 0 = manual
- fixed_shift  in  SHIFT_W  manual shift amount
- I_out_tdata  out  OUT_WIDTH  scaled, saturated I
- I_out_tvalid  out  1  output valid
- Q_out_tdata  out  OUT_WIDTH  scaled, saturated Q
- Q_out_tvalid  out  1  output valid (always equal to I_out_tvalid)
- shift_cur  out  SHIFT_W  shift currently applied
- sat  out  1  the output sample in this cycle was clipped (I or Q)
- locked  out  1  tracking is stable

## Operation
- **Sample acceptance**
  - A sample is accepted when I_in_tvalid && Q_in_tvalid.
  - If only one valid is high, the sample is ignored and output valid is 0.
- **Datapath** (for each accepted sample)
  - Compute y = x >>> shift_cur (arithmetic shift).
  - Saturate y to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1].
  - sat = 1 if either channel clipped.
  - When not accepting, output data and sat are 0.
- **Magnitude**
  - m = max(|I|, |Q|), with |−2^(WIDTH−1)| saturated to 2^(WIDTH−1)−1.
  - peak = running max of m over the window, including the current sample.
- **Target shift**
  - p = index of the highest set bit of the window peak (p = 0 if peak = 0).
  - target = clamp(p − TARGET_MSB, 0, MAX_SHIFT).
- **FSM** (state register is internal; the encoding is free)
  - MANUAL
    - Entered when auto_en = 0.
    - shift_cur ← fixed_shift every cycle; window counter and peak are held at 0; locked = 0.
    - On auto_en = 1 → ACQ, starting from the current shift_cur.
  - ACQ
    - Count accepted samples.
    - At the last sample of the window: shift_cur ← target; go to TRACK; clear peak and counter.
  - TRACK
    - At each window end: shift_cur moves toward target by at most 1 (+1, −1 or 0).
    - locked ← (target == shift_cur before the update); locked updates only at window end.
  - auto_en = 0 in any state → MANUAL on the next edge. A partial window is discarded and locked ← 0.
- **Window counter**
  - WIN_LOG2 bits, wraps to 0 after the last sample.
  - Advances only on accepted samples; gaps in valid do not end a window.

## Timing
- **Latency:** 1 cycle from acceptance to output. Output valid is the registered acceptance.
- **Shift used:** the value of shift_cur at the acceptance edge. The last sample of a window uses the old shift; the new shift applies from the next accepted sample.
- **shift_cur visibility:** a new value is visible the cycle after the window-end edge.
- **MANUAL mode:** a fixed_shift change applies to samples accepted from the next cycle.
- **Reset (asynchronous, any time, including mid-window):**
  - All data and valid outputs, sat and locked = 0.
  - shift_cur = INIT_SHIFT; state = ACQ if auto_en else MANUAL (evaluated after release); counter = 0; peak = 0.
- **Throughput:** one sample per cycle, no back-pressure.

## Test plan
Parameters used by the bench: WIDTH=16, OUT_WIDTH=12, TARGET_MSB=9, WIN_LOG2=6, INIT_SHIFT=0.
- **Manual scaling:** auto_en=0, fixed_shift=2, I=−100, Q=37, both valid → next cycle I_out=−25, Q_out=9, valids=1, sat=0. Then I valid only → valids=0, data=0.
- **Saturation:** manual, fixed_shift=0, I=32767, Q=−32768 → I_out=2047, Q_out=−2048, sat=1.
- **Acquisition:** auto_en=1, 64 samples I=8000, Q=0 (p=12, target=3) → shift_cur=3 after the 64th sample; sample 64 out=500; sample 65 out=1000; state TRACK.
- **Tracking slew and lock:** from shift 3 in TRACK, windows of amplitude 200 (target 0) → shift 2, 1, 0 after successive windows; locked goes 1 at the fourth window end. Insert valid gaps mid-window: window length is unchanged.
- **Abs corner:** window peak sample Q=−32768 → magnitude 32767, p=14, target 5, shift_cur=5 after ACQ.
- **Reset and mode switch:** drop rst_n mid-window in TRACK → all outputs 0 immediately, shift_cur=0. Separately, deassert auto_en mid-window with fixed_shift=4 → shift_cur=4 next cycle, locked=0, partial window discarded.
